// File: rtl/acacia_pkg.sv
// Shared types and defaults for the acacia request front-end.
package acacia_pkg;

  localparam int unsigned NCLI         = 3;
  localparam int unsigned DEF_CNT_W    = 3;
  localparam int unsigned DEF_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SAT  = 2'd2
  } client_st_e;

  // LSB of client idx's field inside the packed pend_cnt bus.
  function automatic int unsigned pend_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/acacia_req_slot.sv
// One client's pending counter, request FSM and overflow flag.
// Wait timer / starvation flag present only with ACACIA_STARVE_MON_EN defined.
module acacia_req_slot
  import acacia_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             grant,
  output logic [CNT_W-1:0] cnt,
  output logic             req,
  output logic             ovf,
  output logic             starve
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (CNT_W < 1 || MAX_WAIT < 1) begin : g_bad_cfg
    $error("acacia_req_slot: CNT_W and MAX_WAIT must both be at least 1");
  end

  client_st_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case ({push, grant})
      2'b10: begin
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_ONE;
      end
      2'b01: begin
        // A grant with nothing pending is a park grant and is ignored.
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
      end
      2'b11: begin
        // Push and grant cancel, except an uncredited grant at zero.
        if (cnt_q == '0) cnt_d = CNT_ONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cnt_d != '0) state_d = (cnt_d == CNT_MAX) ? ST_SAT : ST_PEND;
      ST_PEND: begin
        if (cnt_d == '0)          state_d = ST_IDLE;
        else if (cnt_d == CNT_MAX) state_d = ST_SAT;
      end
      ST_SAT: begin
        if (cnt_d == '0)           state_d = ST_IDLE;
        else if (cnt_d != CNT_MAX) state_d = ST_PEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign req = (state_q != ST_IDLE);
  assign ovf = ovf_q;

`ifdef ACACIA_STARVE_MON_EN
  localparam int unsigned   TW       = $clog2(MAX_WAIT + 1);
  localparam logic [TW-1:0] WAIT_MAX = TW'(MAX_WAIT);

  logic [TW-1:0] wait_q, wait_d;
  logic          starve_q, starve_d;

  always_comb begin
    wait_d   = wait_q;
    starve_d = starve_q;
    if (!req || grant) wait_d = '0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + TW'(1);
    if (wait_d == WAIT_MAX) starve_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: rtl/acacia_req_front.sv
// Request front-end for the 3-client arbiter: per-client pending slots plus
// a sticky grant-exclusivity checker. Starvation monitor: ACACIA_STARVE_MON_EN.
module acacia_req_front
  import acacia_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCLI-1:0]       push,
  input  logic                  a0,
  input  logic                  a1,
  input  logic                  a2,
  output logic                  r0,
  output logic                  r1,
  output logic                  r2,
  output logic [NCLI*CNT_W-1:0] pend_cnt,
  output logic [NCLI-1:0]       ovf,
  output logic                  mutex_err,
  output logic [NCLI-1:0]       starve
);

  logic [NCLI-1:0] grant, req;
  logic            multi_grant;
  logic            mutex_q, mutex_d;

  assign grant = {a2, a1, a0};

  for (genvar i = 0; i < NCLI; i++) begin : g_slot
    acacia_req_slot #(
      .CNT_W   (CNT_W),
      .MAX_WAIT(MAX_WAIT)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .grant (grant[i]),
      .cnt   (pend_cnt[pend_lsb(i, CNT_W) +: CNT_W]),
      .req   (req[i]),
      .ovf   (ovf[i]),
      .starve(starve[i])
    );
  end

  assign {r2, r1, r0} = req;

  // Each granted slot still retires its own unit; this only records the fault.
  assign multi_grant = (a0 & a1) | (a0 & a2) | (a1 & a2);

  always_comb begin
    mutex_d = mutex_q | multi_grant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) mutex_q <= 1'b0;
    else        mutex_q <= mutex_d;
  end

  assign mutex_err = mutex_q;

endmodule
